mem_bus_sequencer: RTL and testbench
====================================

// Module: mem_bus_sequencer
// PURPOSE
// - Shares the CPU's single Avalon-MM memory port between instruction fetch and data load/store.
// - Sequences one transfer at a time and returns read data to the requester.
// - Drives the stall line back to the PC/next-instruction unit, freezing its FETCH/EXEC1/EXEC2 stepping while memory is busy.
// - Sits between the CPU core (PC unit, load/store logic) and the top-level bus pins.
// PARAMETERS
// - ADDR_W    32   byte address width
// - DATA_W    32   bus data width; byteenable width is DATA_W/8
// - MAX_WAIT  255  waitrequest cycles tolerated per transfer before timeout
// PORTS
// - clk        in   1       single clock; all state changes on posedge
// - rst        in   1       synchronous, active-high reset
// - if_req     in   1       fetch request; level, held with if_addr until if_valid
// - if_addr    in   ADDR_W  fetch byte address
// - if_rdata   out  DATA_W  fetched instruction word (registered)
// - if_valid   out  1       1-cycle pulse: fetch complete
// - d_req      in   1       data request; level, operands held until d_valid
// - d_we       in   1       1=store, 0=load
// - d_addr     in   ADDR_W  data byte address
// - d_wdata    in   DATA_W  store data
// - d_byteen   in   DATA_W/8  store/load byte lanes
// - d_rdata    out  DATA_W  load data (registered)
// - d_valid    out  1       1-cycle pulse: load/store complete
// - address    out  ADDR_W  bus address, low 2 bits forced 0
// - read       out  1       bus read strobe
// - write      out  1       bus write strobe
// - byteenable out  DATA_W/8  bus lanes
// - writedata  out  DATA_W  bus store data
// - waitrequest in  1       slave stall; transfer completes in a strobe cycle with waitrequest=0
// - readdata   in   DATA_W  valid in completing read cycle
// - stall      out  1       to PC unit
// - bus_error  out  1       sticky timeout flag
// BEHAVIOUR
// - Reset: state=IDLE; read/write/valids/bus_error=0; address/writedata/byteenable/rdata regs=0; stall=0 while rst=1.
// - Reset applied mid-transfer: strobes drop at the same edge; the slave transaction is abandoned.
// - FSM states:
//   - IDLE: samples requests. d_req wins over if_req (fixed priority); the loser waits. Winner's operands are registered; go to BUS.
//   - BUS: exactly one of read/write high with registered address/byteenable/writedata.
//     - Stay while waitrequest=1.
//     - waitrequest=0 -> capture readdata (reads only) into the winner's rdata reg; go to DONE.
//   - DONE: winner's valid=1 for this cycle only; go to IDLE. Requests are NOT sampled in DONE.
//   - ERROR: entered from BUS when wait count reaches MAX_WAIT. Strobes drop, bus_error=1, stall=1. Held until rst.
// - Strobe and lane rules:
//   - Fetch: read=1, byteenable=all ones.
//   - Load: read=1, byteenable=d_byteen.
//   - Store: write=1, byteenable=d_byteen.
//   - read&write never both 1.
// - Data registers:
//   - Stores pulse d_valid and leave d_rdata unchanged.
//   - if_rdata/d_rdata hold until overwritten by the next read of the same requester.
// - Latency: request seen in IDLE cycle n -> strobe from n+1 -> valid at n+2+W (W = waitrequest-high cycles).
// - stall = ~rst & (ERROR | ((if_req|d_req) & ~(if_valid|d_valid))); combinational, deasserts in the valid cycle.
// - Wait counter:
//   - Clears on BUS entry; increments each BUS cycle with waitrequest=1.
//   - Saturates, no wrap.
//   - Timeout is checked before completion: count==MAX_WAIT with waitrequest=1 -> ERROR.
// - Request dropped early:
//   - A req dropped before its transfer starts is never issued.
//   - A req dropped during BUS does not abort; valid still pulses.
// STRUCTURE
// - Package bus_pkg:
//   - seq_state_t enum {IDLE,BUS,DONE,ERROR}
//   - grant_t enum {GNT_IF,GNT_D}
//   - BYTEEN_ALL, MAX_WAIT_DEFAULT
// - Sub-module bus_wait_timer: saturating counter with clear/inc, timeout output at MAX_WAIT.
// TESTING
// - Fetch 0xBFC00000, waitrequest=0, readdata=0x24020005:
//   - read=1 at n+1; if_valid=1 and if_rdata=0x24020005 at n+2; stall low at n+2.
// - Load 0x00001003, byteen=4'b1000, waitrequest high 3 cycles:
//   - address=0x00001000, byteenable=4'b1000; d_valid at n+5; stall high n..n+4.
// - if_req and d_req both rise same cycle, store 0xDEADBEEF:
//   - write first, d_valid; fetch read issued only after IDLE revisited; if_valid 3 cycles after d_valid.
// - waitrequest stuck high with MAX_WAIT=4:
//   - strobes drop after 4 wait cycles; bus_error=1 and stall=1 persist; rst clears both.
// - rst asserted during BUS with waitrequest=1:
//   - next cycle read=0, state IDLE, no valid pulse, bus_error=0.
// - Store completion: d_valid pulses, d_rdata keeps prior load value 0x12345678.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU memory-port sequencer.
package bus_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        DONE  = 2'd2,
        ERROR = 2'd3
    } seq_state_t;

    // Which requester owns the transfer in flight.
    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } grant_t;

    localparam int          DATA_W_DEFAULT   = 32;
    localparam int          MAX_WAIT_DEFAULT = 255;
    localparam logic [DATA_W_DEFAULT/8-1:0] BYTEEN_ALL = '1;

endpackage

// File: rtl/bus_wait_timer.sv
// Saturating waitrequest counter with a timeout flag at MAX_WAIT.
module bus_wait_timer
    import bus_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic timeout
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] count;

    // Count stalled bus cycles; clear wins over increment, and the count parks at MAX_WAIT.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != CNT_W'(MAX_WAIT))) begin
            count <= count + 1'b1;
        end
    end

    assign timeout = (count == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_bus_sequencer.sv
// Arbitrates the single Avalon-MM port between fetch and load/store, one transfer at a time.
module mem_bus_sequencer
    import bus_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = DATA_W_DEFAULT,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_byteen,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_valid,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W/8-1:0] byteenable,
    output logic [DATA_W-1:0]   writedata,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata,
    output logic                stall,
    output logic                bus_error
);

    // Word-align mask: the bus always sees the low two address bits as zero.
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    seq_state_t state;
    grant_t     grant;
    logic       timeout;

    // The counter is held at zero outside BUS, so it always starts fresh on BUS entry.
    bus_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state != BUS),
        .inc     ((state == BUS) && waitrequest),
        .timeout (timeout)
    );

    // Sequencer FSM with registered bus strobes, lanes, read data and completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= GNT_IF;
            address    <= '0;
            read       <= 1'b0;
            write      <= 1'b0;
            byteenable <= '0;
            writedata  <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_valid   <= 1'b0;
            d_valid    <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            // Completion pulses default low so they last exactly one cycle.
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (d_req) begin
                        grant      <= GNT_D;
                        address    <= d_addr & WORD_MASK;
                        read       <= ~d_we;
                        write      <= d_we;
                        byteenable <= d_byteen;
                        writedata  <= d_wdata;
                        state      <= BUS;
                    end else if (if_req) begin
                        grant      <= GNT_IF;
                        address    <= if_addr & WORD_MASK;
                        read       <= 1'b1;
                        write      <= 1'b0;
                        byteenable <= '1;
                        state      <= BUS;
                    end
                end
                BUS: begin
                    // Timeout takes precedence over a completion in the same cycle.
                    if (waitrequest && timeout) begin
                        read      <= 1'b0;
                        write     <= 1'b0;
                        bus_error <= 1'b1;
                        state     <= ERROR;
                    end else if (!waitrequest) begin
                        read  <= 1'b0;
                        write <= 1'b0;
                        if (grant == GNT_D) begin
                            d_valid <= 1'b1;
                            if (read) begin
                                d_rdata <= readdata;
                            end
                        end else begin
                            if_valid <= 1'b1;
                            if_rdata <= readdata;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Freeze the PC unit while a request is outstanding or after a bus timeout.
    assign stall = ~rst & ((state == ERROR) | ((if_req | d_req) & ~(if_valid | d_valid)));

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Directed self-checking bench for mem_bus_sequencer.
module tb_mem_bus_sequencer;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_byteen;
    logic [DATA_W-1:0] d_rdata;
    logic              d_valid;
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [3:0]        byteenable;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              stall;
    logic              bus_error;

    int n_vec = 0;
    int n_err = 0;

    mem_bus_sequencer #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_WAIT (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_valid    (if_valid),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_byteen    (d_byteen),
        .d_rdata     (d_rdata),
        .d_valid     (d_valid),
        .address     (address),
        .read        (read),
        .write       (write),
        .byteenable  (byteenable),
        .writedata   (writedata),
        .waitrequest (waitrequest),
        .readdata    (readdata),
        .stall       (stall),
        .bus_error   (bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; d_byteen = '0; waitrequest = 1'b0; readdata = '0;

        // Reset state, with a pending fetch that must not raise stall.
        step(); step();
        if_req = 1'b1;
        #1;
        check("rst_stall", stall, 0);
        check("rst_read", read, 0);
        check("rst_write", write, 0);
        check("rst_bus_error", bus_error, 0);
        check("rst_address", address, 0);
        check("rst_valids", {if_valid, d_valid}, 0);
        if_req = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Fetch with no wait states.
        if_req = 1'b1; if_addr = 32'hBFC0_0000; readdata = 32'h2402_0005;
        #1;
        check("f_stall_n", stall, 1);
        step();
        check("f_read_n1", read, 1);
        check("f_write_n1", write, 0);
        check("f_addr_n1", address, 32'hBFC0_0000);
        check("f_be_n1", byteenable, 4'hF);
        check("f_valid_n1", if_valid, 0);
        step();
        check("f_valid_n2", if_valid, 1);
        check("f_rdata_n2", if_rdata, 32'h2402_0005);
        check("f_stall_n2", stall, 0);
        if_req = 1'b0;
        step();
        check("f_valid_n3", if_valid, 0);

        // Load at an unaligned address, three wait cycles.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_1003; d_byteen = 4'b1000;
        waitrequest = 1'b1; readdata = 32'hFFFF_FFFF;
        #1;
        check("l_stall_n", stall, 1);
        step();
        check("l_read_n1", read, 1);
        check("l_addr_n1", address, 32'h0000_1000);
        check("l_be_n1", byteenable, 4'b1000);
        check("l_stall_n1", stall, 1);
        step();
        check("l_stall_n2", stall, 1);
        step();
        check("l_stall_n3", stall, 1);
        check("l_read_n3", read, 1);
        step();
        waitrequest = 1'b0; readdata = 32'h1234_5678;
        #1;
        check("l_stall_n4", stall, 1);
        check("l_valid_n4", d_valid, 0);
        step();
        check("l_valid_n5", d_valid, 1);
        check("l_rdata_n5", d_rdata, 32'h1234_5678);
        check("l_stall_n5", stall, 0);
        d_req = 1'b0;
        step();

        // Simultaneous fetch and store: store wins, fetch follows after IDLE.
        if_req = 1'b1; if_addr = 32'hBFC0_0004;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF; d_byteen = 4'hF;
        readdata = 32'h5555_5555;
        step();
        check("s_write_n1", write, 1);
        check("s_read_n1", read, 0);
        check("s_wdata_n1", writedata, 32'hDEAD_BEEF);
        check("s_addr_n1", address, 32'h0000_2000);
        step();
        check("s_dvalid_n2", d_valid, 1);
        check("s_ivalid_n2", if_valid, 0);
        check("s_drdata_kept", d_rdata, 32'h1234_5678);
        d_req = 1'b0;
        step();
        check("s_read_n3", read | write, 0);
        step();
        check("s_fread_n4", read, 1);
        check("s_faddr_n4", address, 32'hBFC0_0004);
        readdata = 32'h8FA2_0000;
        step();
        check("s_ivalid_n5", if_valid, 1);
        check("s_irdata_n5", if_rdata, 32'h8FA2_0000);
        if_req = 1'b0;
        step();

        // Reset in the middle of a stalled load.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_3000; d_byteen = 4'hF; waitrequest = 1'b1;
        step();
        check("r_read_bus", read, 1);
        rst = 1'b1; d_req = 1'b0;
        step();
        check("r_read_after", read, 0);
        check("r_dvalid_after", d_valid, 0);
        check("r_bus_error", bus_error, 0);
        rst = 1'b0; waitrequest = 1'b0;
        step();
        check("r_idle_read", read, 0);
        step();
        check("r_no_valid", {if_valid, d_valid}, 0);

        // waitrequest stuck high: timeout into ERROR.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_4000; waitrequest = 1'b1;
        step();
        check("t_read_n1", read, 1);
        for (int i = 0; i < 7; i++) step();
        check("t_read_dropped", read, 0);
        check("t_bus_error", bus_error, 1);
        check("t_stall", stall, 1);
        check("t_no_valid", d_valid, 0);
        d_req = 1'b0; waitrequest = 1'b0;
        step(); step();
        check("t_error_held", bus_error, 1);
        check("t_stall_held", stall, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("t_rst_error", bus_error, 0);
        check("t_rst_stall", stall, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
